lfsr_gen: RTL

- Parametrised successor to the fixed 26-bit LFSR.
- Width and tap polynomial are parameters, and the register runs in either Fibonacci or Galois form, selected at run time.
- Adds a full-width seed load, a step enable, automatic recovery from the all-zero lock-up state, and period measurement against the loaded seed.
- Feeds pseudo-random words and a serial bit stream to test-pattern and scrambler logic.

---
 rtl/lfsr_gen.sv | 85 ++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR with run-time Fibonacci/Galois selection,
// seed load, step enable, all-zero lock-up recovery and period measurement
// against the most recently loaded (or recovered) seed.
module lfsr_gen #(
  parameter int             N          = 26,
  parameter logic [N-1:0]   TAPS       = N'(26'h2000023),
  parameter logic [N-1:0]   RESET_SEED = N'(1),
  parameter logic [N-1:0]   RESEED     = N'(1)
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         mode,
  output logic [N-1:0] q,
  output logic [N-1:0] qbar,
  output logic         bit_out,
  output logic         lockup,
  output logic         wrap,
  output logic [N-1:0] step_count,
  output logic [N-1:0] period,
  output logic         period_valid
);

  logic [N-1:0] ref_seed;
  logic         fb;
  logic [N-1:0] fib_nxt;
  logic [N-1:0] gal_nxt;
  logic [N-1:0] step_nxt;
  logic         hit;

  // Candidate next state for both forms; mode picks one every enabled step
  always_comb begin
    fb       = ^(q & TAPS);
    fib_nxt  = {q[N-2:0], fb};
    gal_nxt  = {q[N-2:0], 1'b0} ^ (q[N-1] ? TAPS : '0);
    step_nxt = mode ? gal_nxt : fib_nxt;
    hit      = (step_nxt == ref_seed);
  end

  assign qbar    = ~q;
  assign bit_out = q[N-1];

  // Register state, reference seed, step counter and period measurement
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      q            <= RESET_SEED;
      ref_seed     <= RESET_SEED;
      step_count   <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      lockup       <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
      if (load) begin
        q          <= seed;
        ref_seed   <= seed;
        step_count <= '0;
      end else if (en) begin
        if (q == '0) begin
          // All-zero is a fixed point of both forms; restart from RESEED
          // and measure the period from there.
          q          <= RESEED;
          ref_seed   <= RESEED;
          step_count <= '0;
          lockup     <= 1'b1;
        end else begin
          q <= step_nxt;
          if (hit) begin
            wrap         <= 1'b1;
            period       <= step_count + N'(1);
            period_valid <= 1'b1;
            step_count   <= '0;
          end else begin
            step_count <= step_count + N'(1);
          end
        end
      end
    end
  end

endmodule
